// File: rtl/im2col_sched_if.sv
// im2col scheduler bus: sweep configuration and control
// in, patch origins and sweep status out.
interface im2col_sched_if #(
  parameter int h = 512,
  parameter int w = 512,
  parameter int k = 16
);
  localparam int h_width = $clog2(h);
  localparam int w_width = $clog2(w);
  localparam int k_width = $clog2(k);
  localparam int c_width = $clog2(h * w) + 1;

  logic [h_width-1:0] im_h;
  logic [w_width-1:0] im_w;
  logic [k_width-1:0] k_h;
  logic [k_width-1:0] k_w;
  logic [k_width-1:0] stride;
  logic               start;
  logic               abort;
  logic               patch_ready;
  logic               patch_valid;
  logic [h_width-1:0] patch_row;
  logic [w_width-1:0] patch_col;
  logic               patch_last;
  logic [c_width-1:0] patch_count;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output im_h, im_w, k_h, k_w, stride,
    output start, abort, patch_ready,
    input  patch_valid, patch_row, patch_col,
    input  patch_last, patch_count,
    input  busy, done, err
  );

  modport slave (
    input  im_h, im_w, k_h, k_w, stride,
    input  start, abort, patch_ready,
    output patch_valid, patch_row, patch_col,
    output patch_last, patch_count,
    output busy, done, err
  );
endinterface

// File: rtl/im2col_sched.sv
// Raster-order patch origin scheduler for im2col/GEMM.
// Walks patch top-left corners with a shared stride.
module im2col_sched #(
  parameter int h = 512,
  parameter int w = 512,
  parameter int k = 16
) (
  input logic           clk,
  input logic           reset,
  im2col_sched_if.slave bus
);
  localparam int h_width = $clog2(h);
  localparam int w_width = $clog2(w);
  localparam int k_width = $clog2(k);
  localparam int c_width = $clog2(h * w) + 1;
  localparam int h1 = h_width + 1;
  localparam int w1 = w_width + 1;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    ISSUE,
    FINISH
  } state_t;

  state_t             state_q, state_d;
  logic [h_width-1:0] im_h_q, im_h_d;
  logic [w_width-1:0] im_w_q, im_w_d;
  logic [k_width-1:0] k_h_q, k_h_d;
  logic [k_width-1:0] k_w_q, k_w_d;
  logic [k_width-1:0] stride_q, stride_d;
  logic [h_width-1:0] row_q, row_d;
  logic [w_width-1:0] col_q, col_d;
  logic [c_width-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic [w1-1:0] col_end;
  logic [h1-1:0] row_end;
  logic          col_adv;
  logic          row_adv;
  logic          illegal;
  logic          issue;

  // Origins never exceed im-k, so one extra bit holds the sums.
  always_comb begin
    col_end = w1'(col_q) + w1'(stride_q)
            + w1'(k_w_q);
    row_end = h1'(row_q) + h1'(stride_q)
            + h1'(k_h_q);
    col_adv = col_end <= w1'(im_w_q);
    row_adv = row_end <= h1'(im_h_q);
    illegal = (k_h_q == '0)
           || (k_w_q == '0)
           || (stride_q == '0)
           || (h1'(k_h_q) > h1'(im_h_q))
           || (w1'(k_w_q) > w1'(im_w_q));
    issue   = state_q == ISSUE;
  end

  always_comb begin
    state_d  = state_q;
    im_h_d   = im_h_q;
    im_w_d   = im_w_q;
    k_h_d    = k_h_q;
    k_w_d    = k_w_q;
    stride_d = stride_q;
    row_d    = row_q;
    col_d    = col_q;
    count_d  = count_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          im_h_d   = bus.im_h;
          im_w_d   = bus.im_w;
          k_h_d    = bus.k_h;
          k_w_d    = bus.k_w;
          stride_d = bus.stride;
          count_d  = '0;
          err_d    = 1'b0;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (illegal) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          row_d   = '0;
          col_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.patch_ready) begin
          count_d = count_q + 1'b1;
          unique case (1'b1)
            col_adv: begin
              col_d = col_q + w_width'(stride_q);
            end
            !col_adv && row_adv: begin
              col_d = '0;
              row_d = row_q + h_width'(stride_q);
            end
            default: state_d = FINISH;
          endcase
        end
      end
      FINISH: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort drops the sweep, including any same-cycle accept.
    if (bus.abort && state_q != IDLE) begin
      row_d   = row_q;
      col_d   = col_q;
      count_d = count_q;
      err_d   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      im_h_q   <= '0;
      im_w_q   <= '0;
      k_h_q    <= '0;
      k_w_q    <= '0;
      stride_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      im_h_q   <= im_h_d;
      im_w_q   <= im_w_d;
      k_h_q    <= k_h_d;
      k_w_q    <= k_w_d;
      stride_q <= stride_d;
      row_q    <= row_d;
      col_q    <= col_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign bus.patch_valid = issue;
  assign bus.patch_row   = row_q;
  assign bus.patch_col   = col_q;
  assign bus.patch_last  = issue && !col_adv
                        && !row_adv;
  assign bus.patch_count = count_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = (state_q == FINISH)
                        && !bus.abort;
  assign bus.err         = bus.done && err_q;
endmodule

// File: tb/tb_im2col_sched.sv
// Randomized scoreboard bench for im2col_sched.
// Expected patches come from closed-form patch grid math.
module tb_im2col_sched;
  localparam int H  = 512;
  localparam int W  = 512;
  localparam int K  = 16;
  localparam int HW = $clog2(H);
  localparam int WW = $clog2(W);
  localparam int KW = $clog2(K);

  typedef struct {
    int r;
    int c;
    bit last;
  } patch_t;

  typedef struct {
    bit err;
    int cnt;
  } fin_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  im2col_sched_if #(.h(H), .w(W), .k(K)) bus ();

  im2col_sched #(.h(H), .w(W), .k(K)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  patch_t exp_q[$];
  fin_t   fin_q[$];
  int total = 0;
  int bad = 0;
  int acc_total = 0;
  int acc_base = 0;
  int done_cnt = 0;
  int cyc = 0;
  int last_cyc = -10;
  int prev_done = 0;

  task automatic check(input string nm,
                       input longint act,
                       input longint want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d t=%0t",
               nm, act, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Patch grid: rows (ih-kh)/s+1 by cols (iw-kw)/s+1.
  function automatic int build(input int ih, input int iw,
                               input int kh, input int kw,
                               input int s);
    int nr;
    int nc;
    fin_t f;
    patch_t p;
    if (kh == 0 || kw == 0 || s == 0 || kh > ih || kw > iw) begin
      f.err = 1'b1;
      f.cnt = 0;
      fin_q.push_back(f);
      return 0;
    end
    nr = (ih - kh) / s + 1;
    nc = (iw - kw) / s + 1;
    for (int i = 0; i < nr; i++) begin
      for (int j = 0; j < nc; j++) begin
        p.r = i * s;
        p.c = j * s;
        p.last = (i == nr - 1) && (j == nc - 1);
        exp_q.push_back(p);
      end
    end
    f.err = 1'b0;
    f.cnt = nr * nc;
    fin_q.push_back(f);
    return nr * nc;
  endfunction

  task automatic scramble();
    bus.im_h   = HW'($urandom);
    bus.im_w   = WW'($urandom);
    bus.k_h    = KW'($urandom);
    bus.k_w    = KW'($urandom);
    bus.stride = KW'($urandom);
  endtask

  task automatic set_cfg(input int ih, input int iw,
                         input int kh, input int kw,
                         input int s);
    bus.im_h   = HW'(ih);
    bus.im_w   = WW'(iw);
    bus.k_h    = KW'(kh);
    bus.k_w    = KW'(kw);
    bus.stride = KW'(s);
  endtask

  task automatic run_sweep(input int ih, input int iw,
                           input int kh, input int kw,
                           input int s, input int pct,
                           input bit stall,
                           input bit with_abort);
    int d0;
    int n;
    int cnt;
    bit legal;
    bit stalled;
    legal = !(kh == 0 || kw == 0 || s == 0
              || kh > ih || kw > iw);
    cnt = build(ih, iw, kh, kw, s);
    acc_base = acc_total;
    d0 = done_cnt;
    stalled = 1'b0;
    set_cfg(ih, iw, kh, kw, s);
    bus.start = 1'b1;
    bus.abort = with_abort;
    bus.patch_ready = ($urandom_range(99) < pct);
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    scramble();
    check("start_busy", bus.busy, 1);
    check("check_valid", bus.patch_valid, 0);
    check("check_count", bus.patch_count, 0);
    tick();
    if (legal) begin
      check("first_valid", bus.patch_valid, 1);
      check("first_row", bus.patch_row, 0);
      check("first_col", bus.patch_col, 0);
    end else begin
      check("err_done", bus.done, 1);
      check("err_flag", bus.err, 1);
      check("err_valid", bus.patch_valid, 0);
    end
    n = 0;
    while (done_cnt == d0 && n < 20000) begin
      bus.patch_ready = ($urandom_range(99) < pct);
      scramble();
      tick();
      n++;
      if (stall && !stalled && bus.patch_valid
          && bus.patch_row == 1 && bus.patch_col == 1) begin
        stalled = 1'b1;
        bus.patch_ready = 1'b0;
        repeat (3) begin
          tick();
          check("stall_valid", bus.patch_valid, 1);
          check("stall_row", bus.patch_row, 1);
          check("stall_col", bus.patch_col, 1);
          check("stall_count", bus.patch_count, 4);
        end
      end
    end
    check("sweep_timeout", n < 20000, 1);
    if (stall) check("stall_seen", stalled, 1);
    tick();
    check("end_busy", bus.busy, 0);
    check("end_done", bus.done, 0);
    check("held_count", bus.patch_count, cnt);
    check("left_patches", exp_q.size(), 0);
    check("left_done", fin_q.size(), 0);
    exp_q.delete();
    fin_q.delete();
  endtask

  initial begin
    patch_t p;
    fin_t f;
    int n;
    int ih;
    int iw;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.patch_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
          if (bus.done) begin
            check("done_width", prev_done, 0);
            check("done_valid", bus.patch_valid, 0);
            check("done_expected", fin_q.size() > 0, 1);
            if (fin_q.size() > 0) begin
              f = fin_q.pop_front();
              check("done_err", bus.err, f.err);
              check("final_count", bus.patch_count, f.cnt);
              if (!f.err) check("done_lag", cyc - last_cyc, 1);
            end
            done_cnt++;
          end
          if (bus.patch_valid && bus.patch_ready) begin
            check("patch_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              p = exp_q.pop_front();
              check("patch_row", bus.patch_row, p.r);
              check("patch_col", bus.patch_col, p.c);
              check("patch_last", bus.patch_last, p.last);
              check("acc_count", bus.patch_count,
                    acc_total - acc_base);
              acc_total++;
              if (p.last) last_cyc = cyc;
            end
          end
          prev_done = bus.done;
        end else begin
          prev_done = 0;
        end
      end
    join_none

    repeat (3) tick();
    scramble();
    bus.patch_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    check("rst_valid", bus.patch_valid, 0);
    check("rst_last", bus.patch_last, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_row", bus.patch_row, 0);
    check("rst_col", bus.patch_col, 0);
    check("rst_count", bus.patch_count, 0);
    bus.start = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    run_sweep(5, 5, 3, 3, 1, 100, 0, 0);
    run_sweep(5, 5, 3, 3, 2, 100, 0, 0);
    run_sweep(5, 5, 3, 3, 1, 100, 1, 0);
    run_sweep(5, 5, 6, 3, 1, 70, 0, 0);
    run_sweep(5, 5, 3, 0, 1, 70, 0, 0);
    run_sweep(5, 5, 3, 3, 0, 70, 0, 0);
    run_sweep(5, 4, 3, 5, 1, 70, 0, 0);
    run_sweep(6, 7, 2, 3, 2, 60, 0, 1);
    run_sweep(9, 1, 9, 1, 4, 80, 0, 0);

    for (int i = 0; i < 14; i++) begin
      ih = $urandom_range(1, 20);
      iw = $urandom_range(1, 20);
      run_sweep(ih, iw, $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 5),
                $urandom_range(30, 100), 0, 0);
    end

    // Abort while idle must not disturb anything.
    bus.abort = 1'b1;
    repeat (2) tick();
    check("idle_abort_busy", bus.busy, 0);
    bus.abort = 1'b0;

    // Abort mid-sweep with start pulses during ISSUE.
    n = build(5, 5, 3, 3, 1);
    acc_base = acc_total;
    set_cfg(5, 5, 3, 3, 1);
    bus.patch_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.patch_count != 2 && n < 100) begin
      bus.start = 1'($urandom_range(1));
      tick();
      n++;
    end
    check("abort_reach", bus.patch_count, 2);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    exp_q.delete();
    fin_q.delete();
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.patch_valid, 0);
    check("abort_count", bus.patch_count, 2);
    repeat (5) begin
      tick();
      check("abort_stay", bus.busy, 0);
      check("abort_no_done", bus.done, 0);
    end

    // Reset during a long sweep at patch 4.
    n = build(256, 256, 3, 3, 1);
    acc_base = acc_total;
    set_cfg(256, 256, 3, 3, 1);
    bus.patch_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (bus.patch_count != 4 && n < 100) begin
      tick();
      n++;
    end
    check("mid_reach", bus.patch_count, 4);
    reset = 1'b0;
    tick();
    exp_q.delete();
    fin_q.delete();
    check("mid_valid", bus.patch_valid, 0);
    check("mid_last", bus.patch_last, 0);
    check("mid_done", bus.done, 0);
    check("mid_err", bus.err, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_row", bus.patch_row, 0);
    check("mid_col", bus.patch_col, 0);
    check("mid_count", bus.patch_count, 0);
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_idle", bus.busy, 0);
    end
    run_sweep(5, 5, 3, 3, 1, 50, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
